// File: rtl/uart_dbg_bridge.sv
// ----------------------------------------------------------------------------
// uart_dbg_bridge
//   UART-driven debug master. Parses command frames from a uart_rx byte stream
//   and performs single 32-bit word reads/writes as an initiator on a memif
//   request port. Status and read data are returned through uart_tx.
//
//   Frame    : CMD, A0..A3 (LSB first), [D0..D3 for writes, LSB first]
//              CMD 0x52 = read, 0x57 = write, anything else answers 0x02.
//   Response : read  -> STATUS, R0..R3 (LSB first)
//              write -> STATUS
//              STATUS 0x00 ok, 0x01 bus error, 0x02 unknown command.
//
// Ports
//   g_clk, g_reset        clock, asynchronous active-high reset
//   g_clk_req             clock request while busy or a byte is arriving
//   rx_valid, rx_data     received byte strobe and data (no backpressure)
//   tx_busy               transmitter busy
//   tx_en, tx_data        one-cycle send strobe and byte to send
//   rx_dropped            pulses when a byte arrived while not accepting
//   memif_*               request side of the memory interface:
//                         req, wen, strb, addr, wdata out; gnt, rdata, error in
// ----------------------------------------------------------------------------
module uart_dbg_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        g_clk,
  input  logic        g_reset,
  output logic        g_clk_req,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        tx_busy,
  output logic        tx_en,
  output logic [7:0]  tx_data,
  output logic        rx_dropped,
  output logic        memif_req,
  output logic        memif_wen,
  output logic [3:0]  memif_strb,
  output logic [31:0] memif_addr,
  output logic [31:0] memif_wdata,
  input  logic        memif_gnt,
  input  logic [31:0] memif_rdata,
  input  logic        memif_error
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ADDR    = 3'd1;
  localparam logic [2:0] S_DATA    = 3'd2;
  localparam logic [2:0] S_BUS_REQ = 3'd3;
  localparam logic [2:0] S_BUS_RSP = 3'd4;
  localparam logic [2:0] S_RESP    = 3'd5;

  localparam logic [7:0] CMD_READ   = 8'h52;
  localparam logic [7:0] CMD_WRITE  = 8'h57;
  localparam logic [7:0] ST_OK      = 8'h00;
  localparam logic [7:0] ST_BUSERR  = 8'h01;
  localparam logic [7:0] ST_BADCMD  = 8'h02;

  localparam int unsigned        TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]      TMO_MAX = TW'(TIMEOUT_CYCLES);

  logic [2:0]    state;
  logic          is_write;
  logic [1:0]    byte_cnt;
  logic [31:0]   shift_sr;
  logic [TW-1:0] tmo_cnt;
  logic [7:0]    status_q;
  logic [31:0]   rdata_q;
  logic [2:0]    resp_len;
  logic [2:0]    tx_idx;

  logic [31:0]   assembled;
  logic          in_frame;
  logic          tmo_hit;
  logic          not_accepting;
  logic [7:0]    resp_byte;

  // Bytes arrive LSB first, so each new byte enters at the top and the word
  // is complete once the fourth byte has shifted in.
  assign assembled     = {rx_data, shift_sr[31:8]};
  assign in_frame      = (state == S_ADDR) || (state == S_DATA);
  assign tmo_hit       = (tmo_cnt == TMO_MAX);
  assign not_accepting = (state == S_BUS_REQ) || (state == S_BUS_RSP) || (state == S_RESP);
  assign g_clk_req     = (state != S_IDLE) || rx_valid;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    resp_byte = status_q;
    case (tx_idx)
      3'd1:    resp_byte = rdata_q[7:0];
      3'd2:    resp_byte = rdata_q[15:8];
      3'd3:    resp_byte = rdata_q[23:16];
      3'd4:    resp_byte = rdata_q[31:24];
      default: resp_byte = status_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its neighbours regardless of
  // statement order.
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state       <= S_IDLE;
      is_write    <= 1'b0;
      byte_cnt    <= 2'd0;
      shift_sr    <= 32'd0;
      tmo_cnt     <= '0;
      status_q    <= 8'd0;
      rdata_q     <= 32'd0;
      resp_len    <= 3'd0;
      tx_idx      <= 3'd0;
      tx_en       <= 1'b0;
      tx_data     <= 8'd0;
      rx_dropped  <= 1'b0;
      memif_req   <= 1'b0;
      memif_wen   <= 1'b0;
      memif_strb  <= 4'h0;
      memif_addr  <= 32'd0;
      memif_wdata <= 32'd0;
    end else begin
      tx_en      <= 1'b0;
      rx_dropped <= rx_valid && not_accepting;

      // Inter-byte timeout: only runs while a frame is being collected.
      if (in_frame) begin
        if (rx_valid)      tmo_cnt <= '0;
        else if (!tmo_hit) tmo_cnt <= tmo_cnt + 1'b1;
      end else begin
        tmo_cnt <= '0;
      end

      case (state)
        S_IDLE: begin
          if (rx_valid) begin
            byte_cnt <= 2'd0;
            tx_idx   <= 3'd0;
            if (rx_data == CMD_READ || rx_data == CMD_WRITE) begin
              is_write <= (rx_data == CMD_WRITE);
              state    <= S_ADDR;
            end else begin
              status_q <= ST_BADCMD;
              resp_len <= 3'd1;
              state    <= S_RESP;
            end
          end
        end

        S_ADDR: begin
          if (rx_valid) begin
            shift_sr <= assembled;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              // Word access only: the low address bits are dropped.
              memif_addr <= {assembled[31:2], 2'b00};
              if (is_write) begin
                state <= S_DATA;
              end else begin
                memif_req  <= 1'b1;
                memif_wen  <= 1'b0;
                memif_strb <= 4'hF;
                state      <= S_BUS_REQ;
              end
            end
          end else if (tmo_hit) begin
            state <= S_IDLE;
          end
        end

        S_DATA: begin
          if (rx_valid) begin
            shift_sr <= assembled;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              memif_wdata <= assembled;
              memif_req   <= 1'b1;
              memif_wen   <= 1'b1;
              memif_strb  <= 4'hF;
              state       <= S_BUS_REQ;
            end
          end else if (tmo_hit) begin
            state <= S_IDLE;
          end
        end

        S_BUS_REQ: begin
          // Request and its attributes hold until the arbiter grants.
          if (memif_gnt) begin
            memif_req <= 1'b0;
            state     <= S_BUS_RSP;
          end
        end

        S_BUS_RSP: begin
          // Response phase is the cycle after the grant. A failed read still
          // returns whatever rdata the bus presented.
          status_q <= memif_error ? ST_BUSERR : ST_OK;
          if (!is_write) rdata_q <= memif_rdata;
          resp_len <= is_write ? 3'd1 : 3'd5;
          tx_idx   <= 3'd0;
          state    <= S_RESP;
        end

        S_RESP: begin
          // A pulse is never issued back-to-back; the cycle of the final
          // pulse is spent here and IDLE follows.
          if (tx_en) begin
            if (tx_idx == resp_len) state <= S_IDLE;
          end else if (!tx_busy && tx_idx != resp_len) begin
            tx_en   <= 1'b1;
            tx_data <= resp_byte;
            tx_idx  <= tx_idx + 3'd1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_dbg_bridge.sv
// ----------------------------------------------------------------------------
// tb_uart_dbg_bridge
//   Directed bench for uart_dbg_bridge. A memif responder with programmable
//   grant latency and a UART transmitter model log what the bridge produces;
//   the stimulus sequence pushes expected bus transactions and response bytes
//   into scoreboard queues and compares them against the logs.
// ----------------------------------------------------------------------------
module tb_uart_dbg_bridge;

  localparam int TMO = 40;

  logic        g_clk;
  logic        g_reset;
  logic        g_clk_req;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_busy;
  logic        tx_en;
  logic [7:0]  tx_data;
  logic        rx_dropped;
  logic        memif_req;
  logic        memif_wen;
  logic [3:0]  memif_strb;
  logic [31:0] memif_addr;
  logic [31:0] memif_wdata;
  logic        memif_gnt;
  logic [31:0] memif_rdata;
  logic        memif_error;

  uart_dbg_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
    .g_clk       (g_clk),
    .g_reset     (g_reset),
    .g_clk_req   (g_clk_req),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .tx_busy     (tx_busy),
    .tx_en       (tx_en),
    .tx_data     (tx_data),
    .rx_dropped  (rx_dropped),
    .memif_req   (memif_req),
    .memif_wen   (memif_wen),
    .memif_strb  (memif_strb),
    .memif_addr  (memif_addr),
    .memif_wdata (memif_wdata),
    .memif_gnt   (memif_gnt),
    .memif_rdata (memif_rdata),
    .memif_error (memif_error)
  );

  initial begin
    g_clk = 1'b0;
    forever #5 g_clk = ~g_clk;
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wen;
    logic [3:0]  strb;
    int          waits;
  } mem_t;

  // Logs written only by the monitors below.
  logic [7:0] tx_log[$];
  mem_t       mem_log[$];

  // Scoreboard, owned by the stimulus process.
  logic [7:0] exp_tx[$];
  mem_t       exp_mem[$];
  int         tx_rd  = 0;
  int         mem_rd = 0;
  int         checks = 0;
  int         errors = 0;
  int         gnt_delay = 0;

  // memif responder: grants after gnt_delay waiting cycles and logs the
  // request attributes as seen at the granting edge.
  int wcnt = 0;
  initial memif_gnt = 1'b0;
  always @(negedge g_clk) begin
    mem_t m;
    if (memif_req && wcnt >= gnt_delay) begin
      m.addr  = memif_addr;
      m.wdata = memif_wdata;
      m.wen   = memif_wen;
      m.strb  = memif_strb;
      m.waits = wcnt;
      mem_log.push_back(m);
      memif_gnt = 1'b1;
      wcnt      = 0;
    end else if (memif_req) begin
      memif_gnt = 1'b0;
      wcnt++;
    end else begin
      memif_gnt = 1'b0;
      wcnt      = 0;
    end
  end

  // UART transmitter model: busy for three cycles after each send strobe.
  int busy_cnt = 0;
  initial tx_busy = 1'b0;
  always @(negedge g_clk) begin
    if (busy_cnt > 0) busy_cnt--;
    if (tx_en) begin
      tx_log.push_back(tx_data);
      busy_cnt = 3;
    end
    tx_busy = (busy_cnt > 0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge g_clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge g_clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [31:0] addr,
                            input bit has_data, input logic [31:0] data);
    send_byte(cmd);
    for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8]);
    if (has_data) for (int i = 0; i < 4; i++) send_byte(data[8*i +: 8]);
  endtask

  task automatic expect_mem(input logic [31:0] addr, input logic [31:0] wdata,
                            input logic wen, input int waits);
    mem_t m;
    m.addr  = addr;
    m.wdata = wdata;
    m.wen   = wen;
    m.strb  = 4'hF;
    m.waits = waits;
    exp_mem.push_back(m);
  endtask

  task automatic expect_tx(input logic [7:0] b);
    exp_tx.push_back(b);
  endtask

  // Wait (bounded) for the outstanding expectations, allow a few cycles for
  // any stray output, then compare everything against the logs.
  task automatic drain(input string tag);
    int   n;
    mem_t e;
    mem_t o;
    logic [7:0] b;
    n = 0;
    while ((tx_log.size() < tx_rd + exp_tx.size() ||
            mem_log.size() < mem_rd + exp_mem.size()) && n < 2000) begin
      @(negedge g_clk);
      n++;
    end
    repeat (8) @(negedge g_clk);
    check({tag, " tx count"},  32'(tx_log.size() - tx_rd),   32'(exp_tx.size()));
    check({tag, " mem count"}, 32'(mem_log.size() - mem_rd), 32'(exp_mem.size()));
    while (exp_tx.size() > 0) begin
      b = exp_tx.pop_front();
      if (tx_rd < tx_log.size()) check({tag, " tx byte"}, 32'(tx_log[tx_rd]), 32'(b));
      tx_rd++;
    end
    while (exp_mem.size() > 0) begin
      e = exp_mem.pop_front();
      if (mem_rd < mem_log.size()) begin
        o = mem_log[mem_rd];
        check({tag, " addr"},  o.addr, e.addr);
        check({tag, " wen"},   32'(o.wen), 32'(e.wen));
        check({tag, " strb"},  32'(o.strb), 32'(e.strb));
        check({tag, " waits"}, 32'(o.waits), 32'(e.waits));
        if (e.wen) check({tag, " wdata"}, o.wdata, e.wdata);
      end
      mem_rd++;
    end
    tx_rd  = tx_log.size();
    mem_rd = mem_log.size();
    check({tag, " idle"}, 32'(g_clk_req), 32'd0);
  endtask

  initial begin
    int n;
    g_reset     = 1'b1;
    rx_valid    = 1'b0;
    rx_data     = 8'h00;
    memif_rdata = 32'h0;
    memif_error = 1'b0;
    repeat (3) @(negedge g_clk);

    // Reset values
    check("rst req",    32'(memif_req),  32'd0);
    check("rst wen",    32'(memif_wen),  32'd0);
    check("rst strb",   32'(memif_strb), 32'd0);
    check("rst addr",   memif_addr,      32'd0);
    check("rst wdata",  memif_wdata,     32'd0);
    check("rst tx_en",  32'(tx_en),      32'd0);
    check("rst tx_data",32'(tx_data),    32'd0);
    check("rst drop",   32'(rx_dropped), 32'd0);
    check("rst clk_req",32'(g_clk_req),  32'd0);
    g_reset = 1'b0;
    repeat (2) @(negedge g_clk);

    // 1: write 0xDEADBEEF to 0x1000
    expect_mem(32'h0000_1000, 32'hDEAD_BEEF, 1'b1, 0);
    expect_tx(8'h00);
    send_frame(8'h57, 32'h0000_1000, 1'b1, 32'hDEAD_BEEF);
    drain("t1");

    // 2: read with three wait cycles before grant
    gnt_delay   = 3;
    memif_rdata = 32'h1234_5678;
    expect_mem(32'h0000_1000, 32'h0, 1'b0, 3);
    expect_tx(8'h00); expect_tx(8'h78); expect_tx(8'h56); expect_tx(8'h34); expect_tx(8'h12);
    send_frame(8'h52, 32'h0000_1000, 1'b0, 32'h0);
    drain("t2");
    gnt_delay = 0;

    // 3: misaligned address read with bus error
    memif_rdata = 32'h0;
    memif_error = 1'b1;
    expect_mem(32'h0000_2000, 32'h0, 1'b0, 0);
    expect_tx(8'h01); expect_tx(8'h00); expect_tx(8'h00); expect_tx(8'h00); expect_tx(8'h00);
    send_frame(8'h52, 32'h0000_2003, 1'b0, 32'h0);
    drain("t3");
    memif_error = 1'b0;

    // 4: unknown command, then a normal read right behind it
    @(negedge g_clk);
    rx_valid = 1'b1;
    rx_data  = 8'h41;
    #1 check("t4 clk_req on rx", 32'(g_clk_req), 32'd1);
    @(negedge g_clk);
    rx_valid = 1'b0;
    expect_tx(8'h02);
    drain("t4 badcmd");
    memif_rdata = 32'hCAFE_F00D;
    expect_mem(32'h0000_0000, 32'h0, 1'b0, 0);
    expect_tx(8'h00); expect_tx(8'h0D); expect_tx(8'hF0); expect_tx(8'hFE); expect_tx(8'hCA);
    send_frame(8'h52, 32'h0000_0000, 1'b0, 32'h0);
    drain("t4 read");

    // 5: partial frame abandoned by timeout, then a good write
    send_byte(8'h57);
    send_byte(8'h00);
    send_byte(8'h10);
    check("t5 busy mid-frame", 32'(g_clk_req), 32'd1);
    repeat (TMO + 20) @(negedge g_clk);
    check("t5 idle after timeout", 32'(g_clk_req), 32'd0);
    drain("t5 timeout");
    expect_mem(32'h0000_0004, 32'h4433_2211, 1'b1, 0);
    expect_tx(8'h00);
    send_frame(8'h57, 32'h0000_0004, 1'b1, 32'h4433_2211);
    drain("t5 write");

    // 6a: byte arriving during the response is dropped
    memif_rdata = 32'hA5A5_5A5A;
    expect_mem(32'h0000_0008, 32'h0, 1'b0, 0);
    expect_tx(8'h00); expect_tx(8'h5A); expect_tx(8'h5A); expect_tx(8'hA5); expect_tx(8'hA5);
    send_frame(8'h52, 32'h0000_0008, 1'b0, 32'h0);
    n = 0;
    while (tx_log.size() <= tx_rd && n < 2000) begin
      @(negedge g_clk);
      n++;
    end
    send_byte(8'hAA);
    check("t6 rx_dropped", 32'(rx_dropped), 32'd1);
    drain("t6 resp");

    // 6b: reset while the request is waiting for grant
    gnt_delay = 1000;
    send_frame(8'h52, 32'h0000_3000, 1'b0, 32'h0);
    n = 0;
    while (!memif_req && n < 200) begin
      @(negedge g_clk);
      n++;
    end
    check("t6 req up", 32'(memif_req), 32'd1);
    #2 g_reset = 1'b1;
    #1 check("t6 req async drop", 32'(memif_req), 32'd0);
    @(negedge g_clk);
    g_reset = 1'b0;
    @(negedge g_clk);
    check("t6 idle after reset", 32'(g_clk_req), 32'd0);
    check("t6 addr reset", memif_addr, 32'd0);
    check("t6 strb reset", 32'(memif_strb), 32'd0);
    gnt_delay = 0;
    drain("t6 reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
